// File: rtl/jtag_bridge_pkg.sv
// Shared types and constants for the virtual-JTAG debug bridge.
package jtag_bridge_pkg;

  typedef enum logic [1:0] {
    IR_BYPASS = 2'd0,
    IR_WRITE  = 2'd1,
    IR_READ   = 2'd2,
    IR_CTRL   = 2'd3
  } ir_e;

  localparam int CTRL_W        = 8;
  localparam int CTRL_HALT_BIT = 0;
  localparam int CTRL_CRST_BIT = 1;
  localparam int CTRL_OVF_BIT  = 7;

endpackage

// File: rtl/jtag_strobe_sync.sv
// Brings the TAP signals into the clk domain as one aligned bundle and
// turns synchronised tck into single-cycle rise/fall qualifiers.
module jtag_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tck,
  input  logic       tdi,
  input  logic [1:0] ir_in,
  input  logic       cdr,
  input  logic       sdr,
  input  logic       udr,
  input  logic       uir,
  output logic       rise,
  output logic       fall,
  output logic       tdi_s,
  output logic [1:0] ir_s,
  output logic       cdr_s,
  output logic       sdr_s,
  output logic       udr_s,
  output logic       uir_s
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic       tck_s;
  logic       tck_prev;
  logic       rise_raw;
  logic       fall_raw;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      tck_prev <= 1'b0;
    end else begin
      sync_q[0] <= {uir, udr, sdr, cdr, ir_in, tdi, tck};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      tck_prev <= tck_s;
    end
  end

  assign {uir_s, udr_s, sdr_s, cdr_s, ir_s, tdi_s, tck_s} = sync_q[SYNC_STAGES-1];

  // An edge seen in both directions at once is treated as noise.
  assign rise_raw = tck_s & ~tck_prev;
  assign fall_raw = ~tck_s & tck_prev;
  assign rise     = rise_raw & ~fall_raw;
  assign fall     = fall_raw & ~rise_raw;

endmodule

// File: rtl/jtag_debug_bridge.sv
// Virtual-JTAG to CPU debug-port bridge: WRITE/READ data registers with
// valid/ready handoff. Optional CTRL register enabled by JTAG_BRIDGE_CTRL_EN.
module jtag_debug_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tck,
  input  logic                  tdi,
  input  logic [1:0]            ir_in,
  input  logic                  virtual_state_cdr,
  input  logic                  virtual_state_sdr,
  input  logic                  virtual_state_udr,
  input  logic                  virtual_state_uir,
  output logic                  tdo,
  output logic [1:0]            ir_out,
  output logic                  dbg_wr_valid,
  output logic [DATA_WIDTH-1:0] dbg_wr_data,
  input  logic                  dbg_wr_ready,
  input  logic                  dbg_rd_valid,
  input  logic [DATA_WIDTH-1:0] dbg_rd_data,
  output logic                  dbg_rd_ready,
  output logic                  halt_req,
  output logic                  core_reset_req
);

  logic                  rise, fall, tdi_s, cdr_s, sdr_s, udr_s, uir_s;
  logic [1:0]            ir_s;
  ir_e                   ir_sel;
  logic [DATA_WIDTH-1:0] sr, sr_shift, sr_cap, rd_data;
  logic                  wr_full, rd_full, rd_captured, ovf;
  logic                  ctrl_halt, ctrl_crst;
  logic                  unused_uir;

  jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .tck(tck), .tdi(tdi), .ir_in(ir_in),
    .cdr(virtual_state_cdr), .sdr(virtual_state_sdr),
    .udr(virtual_state_udr), .uir(virtual_state_uir),
    .rise(rise), .fall(fall), .tdi_s(tdi_s), .ir_s(ir_s),
    .cdr_s(cdr_s), .sdr_s(sdr_s), .udr_s(udr_s), .uir_s(uir_s)
  );

  // IR is decoded live from ir_in; the UIR strobe carries no extra meaning here.
  assign unused_uir = uir_s;

  always_comb begin
    ir_sel = ir_e'(ir_s);
`ifndef JTAG_BRIDGE_CTRL_EN
    if (ir_sel == IR_CTRL) ir_sel = IR_BYPASS;
`endif
  end

  // tdi enters at the MSB of whichever register length the IR selects.
  always_comb begin
    sr_shift = sr >> 1;
    case (ir_sel)
      IR_WRITE, IR_READ: sr_shift[DATA_WIDTH-1] = tdi_s;
      IR_CTRL:           sr_shift[CTRL_W-1]     = tdi_s;
      default:           sr_shift = {{(DATA_WIDTH-1){1'b0}}, tdi_s};
    endcase
  end

  always_comb begin
    sr_cap = '0;
    case (ir_sel)
      IR_WRITE: sr_cap[1:0] = {ovf, wr_full};
      IR_READ:  sr_cap = rd_full ? rd_data : '0;
      IR_CTRL: begin
        sr_cap[CTRL_OVF_BIT]  = ovf;
        sr_cap[CTRL_CRST_BIT] = ctrl_crst;
        sr_cap[CTRL_HALT_BIT] = ctrl_halt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr          <= '0;
      tdo         <= 1'b0;
      dbg_wr_data <= '0;
      wr_full     <= 1'b0;
      rd_data     <= '0;
      rd_full     <= 1'b0;
      rd_captured <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (fall) tdo <= sr[0];
      if (rise && cdr_s) begin
        sr <= sr_cap;
        if (ir_sel == IR_READ) rd_captured <= rd_full;
      end else if (rise && sdr_s) begin
        sr <= sr_shift;
      end

      if (wr_full && dbg_wr_ready) wr_full <= 1'b0;
      if (rise && udr_s && ir_sel == IR_WRITE) begin
        if (!wr_full) begin
          dbg_wr_data <= sr;
          wr_full     <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end
`ifdef JTAG_BRIDGE_CTRL_EN
      if (rise && udr_s && ir_sel == IR_CTRL && sr[CTRL_OVF_BIT]) ovf <= 1'b0;
`endif

      // Push and host-side clear are exclusive: a clear needs rd_full high,
      // which holds ready low and refuses any same-cycle push.
      if (dbg_rd_valid && !rd_full) begin
        rd_data <= dbg_rd_data;
        rd_full <= 1'b1;
      end
      if (rise && udr_s && ir_sel == IR_READ && rd_captured) begin
        rd_full     <= 1'b0;
        rd_captured <= 1'b0;
      end
    end
  end

`ifdef JTAG_BRIDGE_CTRL_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_halt <= 1'b0;
      ctrl_crst <= 1'b0;
    end else if (rise && udr_s && ir_sel == IR_CTRL) begin
      ctrl_halt <= sr[CTRL_HALT_BIT];
      ctrl_crst <= sr[CTRL_CRST_BIT];
    end
  end
`else
  assign ctrl_halt = 1'b0;
  assign ctrl_crst = 1'b0;
`endif

  assign ir_out         = {ovf, rd_full};
  assign dbg_wr_valid   = wr_full;
  assign dbg_rd_ready   = ~rd_full;
  assign halt_req       = ctrl_halt;
  assign core_reset_req = ctrl_crst;

endmodule

// File: tb/tb_jtag_debug_bridge.sv
// Directed bench for jtag_debug_bridge; expectations follow JTAG_BRIDGE_CTRL_EN.
module tb_jtag_debug_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tck = 1'b0, tdi = 1'b0;
  logic [1:0]  ir_in = 2'd0;
  logic        cdr = 1'b0, sdr = 1'b0, udr = 1'b0, uir = 1'b0;
  logic        tdo;
  logic [1:0]  ir_out;
  logic        dbg_wr_valid, dbg_wr_ready = 1'b0;
  logic [15:0] dbg_wr_data;
  logic        dbg_rd_valid = 1'b0, dbg_rd_ready;
  logic [15:0] dbg_rd_data = 16'h0;
  logic        halt_req, core_reset_req;

  int          tests = 0;
  int          fails = 0;
  int          hs_count = 0;
  logic [15:0] hs_data = 16'h0;

`ifdef JTAG_BRIDGE_CTRL_EN
  localparam bit CTRL = 1'b1;
`else
  localparam bit CTRL = 1'b0;
`endif

  jtag_debug_bridge #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .tck(tck), .tdi(tdi), .ir_in(ir_in),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr),
    .virtual_state_udr(udr), .virtual_state_uir(uir),
    .tdo(tdo), .ir_out(ir_out),
    .dbg_wr_valid(dbg_wr_valid), .dbg_wr_data(dbg_wr_data), .dbg_wr_ready(dbg_wr_ready),
    .dbg_rd_valid(dbg_rd_valid), .dbg_rd_data(dbg_rd_data), .dbg_rd_ready(dbg_rd_ready),
    .halt_req(halt_req), .core_reset_req(core_reset_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dbg_wr_valid && dbg_wr_ready) begin
      hs_count <= hs_count + 1;
      hs_data  <= dbg_wr_data;
    end
  end

  task automatic tck_cycle(input logic c, input logic s, input logic u, input logic t,
                           output logic o);
    cdr = c; sdr = s; udr = u; tdi = t;
    #50;
    o = tdo;
    tck = 1'b1;
    #50;
    tck = 1'b0;
  endtask

  task automatic scan(input logic [1:0] ir, input int n, input logic [15:0] din,
                      output logic [15:0] dout);
    logic o;
    dout = 16'h0;
    ir_in = ir;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      tck_cycle(1'b0, 1'b1, 1'b0, din[i], o);
      dout[i] = o;
    end
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_rd(input logic [15:0] d);
    @(negedge clk);
    dbg_rd_valid = 1'b1;
    dbg_rd_data  = d;
    @(negedge clk);
    dbg_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (tdo !== 1'b0) begin fails++; $display("FAIL reset_tdo got %b want 0", tdo); end
    tests++; if (ir_out !== 2'b00) begin fails++; $display("FAIL reset_ir_out got %b want 00", ir_out); end
    tests++; if (dbg_wr_valid !== 1'b0) begin fails++; $display("FAIL reset_wr_valid got %b want 0", dbg_wr_valid); end
    tests++; if (dbg_wr_data !== 16'h0) begin fails++; $display("FAIL reset_wr_data got %h want 0000", dbg_wr_data); end
    tests++; if (dbg_rd_ready !== 1'b1) begin fails++; $display("FAIL reset_rd_ready got %b want 1", dbg_rd_ready); end
    tests++; if (halt_req !== 1'b0) begin fails++; $display("FAIL reset_halt got %b want 0", halt_req); end
    tests++; if (core_reset_req !== 1'b0) begin fails++; $display("FAIL reset_crst got %b want 0", core_reset_req); end
  endtask

  task automatic test_write();
    logic [15:0] dout;
    int          hs0;
    dbg_wr_ready = 1'b1;
    hs0 = hs_count;
    scan(2'd1, 16, 16'hA55A, dout);
    @(negedge clk);
    tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL write_capture got %h want 0000", dout); end
    tests++; if (hs_count - hs0 !== 1) begin fails++; $display("FAIL write_handshakes got %0d want 1", hs_count - hs0); end
    tests++; if (hs_data !== 16'hA55A) begin fails++; $display("FAIL write_data got %h want a55a", hs_data); end
    tests++; if (dbg_wr_valid !== 1'b0) begin fails++; $display("FAIL write_valid_after got %b want 0", dbg_wr_valid); end
    tests++; if (ir_out !== 2'b00) begin fails++; $display("FAIL write_ir_out got %b want 00", ir_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dout;
    int          hs0;
    dbg_wr_ready = 1'b1;
    hs0 = hs_count;
    scan(2'd1, 16, 16'h0F0F, dout);
    scan(2'd1, 16, 16'hC3C3, dout);
    @(negedge clk);
    tests++; if (hs_count - hs0 !== 2) begin fails++; $display("FAIL b2b_handshakes got %0d want 2", hs_count - hs0); end
    tests++; if (hs_data !== 16'hC3C3) begin fails++; $display("FAIL b2b_data got %h want c3c3", hs_data); end
    tests++; if (ir_out !== 2'b00) begin fails++; $display("FAIL b2b_ir_out got %b want 00", ir_out); end
  endtask

  task automatic test_overflow();
    logic [15:0] dout;
    logic [15:0] exp_ctrl_out;
    dbg_wr_ready = 1'b0;
    scan(2'd1, 16, 16'h1111, dout);
    scan(2'd1, 16, 16'h2222, dout);
    @(negedge clk);
    tests++; if (dbg_wr_data !== 16'h1111) begin fails++; $display("FAIL ovf_data got %h want 1111", dbg_wr_data); end
    tests++; if (dbg_wr_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid got %b want 1", dbg_wr_valid); end
    tests++; if (ir_out[1] !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", ir_out[1]); end
    scan(2'd1, 16, 16'h3333, dout);
    tests++; if (dout !== 16'h0003) begin fails++; $display("FAIL ovf_capture got %h want 0003", dout); end
    scan(2'd3, 8, 16'h0080, dout);
    @(negedge clk);
    exp_ctrl_out = CTRL ? 16'h0080 : 16'h0000;
    tests++; if (dout !== exp_ctrl_out) begin fails++; $display("FAIL ovf_ctrl_capture got %h want %h", dout, exp_ctrl_out); end
    tests++; if (ir_out[1] !== ~CTRL) begin fails++; $display("FAIL ovf_after_ctrl got %b want %b", ir_out[1], ~CTRL); end
    dbg_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (dbg_wr_valid !== 1'b0) begin fails++; $display("FAIL ovf_drain got %b want 0", dbg_wr_valid); end
  endtask

  task automatic test_read();
    logic [15:0] dout;
    push_rd(16'hBEEF);
    tests++; if (dbg_rd_ready !== 1'b0) begin fails++; $display("FAIL read_ready_low got %b want 0", dbg_rd_ready); end
    tests++; if (ir_out !== 2'b01) begin fails++; $display("FAIL read_pending got %b want 01", ir_out); end
    scan(2'd2, 16, 16'h0000, dout);
    @(negedge clk);
    tests++; if (dout !== 16'hBEEF) begin fails++; $display("FAIL read_word got %h want beef", dout); end
    tests++; if (dbg_rd_ready !== 1'b1) begin fails++; $display("FAIL read_ready_after got %b want 1", dbg_rd_ready); end
    tests++; if (ir_out[0] !== 1'b0) begin fails++; $display("FAIL read_pending_after got %b want 0", ir_out[0]); end
  endtask

  task automatic test_read_race();
    logic [15:0] dout;
    logic        o;
    dout = 16'h0;
    ir_in = 2'd2;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, o);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) push_rd(16'h1234);
      tck_cycle(1'b0, 1'b1, 1'b0, 1'b0, o);
      dout[i] = o;
    end
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, o);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0, o);
    @(negedge clk);
    tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL race_first got %h want 0000", dout); end
    tests++; if (ir_out[0] !== 1'b1) begin fails++; $display("FAIL race_kept got %b want 1", ir_out[0]); end
    tests++; if (dbg_rd_ready !== 1'b0) begin fails++; $display("FAIL race_ready got %b want 0", dbg_rd_ready); end
    scan(2'd2, 16, 16'h0000, dout);
    @(negedge clk);
    tests++; if (dout !== 16'h1234) begin fails++; $display("FAIL race_second got %h want 1234", dout); end
    tests++; if (dbg_rd_ready !== 1'b1) begin fails++; $display("FAIL race_ready_after got %b want 1", dbg_rd_ready); end
  endtask

  task automatic test_ctrl();
    logic [15:0] dout;
    logic [15:0] exp;
    scan(2'd3, 8, 16'h0003, dout);
    @(negedge clk);
    exp = CTRL ? 16'h0000 : 16'h0006;
    tests++; if (dout !== exp) begin fails++; $display("FAIL ctrl_echo got %h want %h", dout, exp); end
    tests++; if (halt_req !== CTRL) begin fails++; $display("FAIL ctrl_halt got %b want %b", halt_req, CTRL); end
    tests++; if (core_reset_req !== CTRL) begin fails++; $display("FAIL ctrl_crst got %b want %b", core_reset_req, CTRL); end
    scan(2'd3, 8, 16'h0000, dout);
    @(negedge clk);
    exp = CTRL ? 16'h0003 : 16'h0000;
    tests++; if (dout !== exp) begin fails++; $display("FAIL ctrl_readback got %h want %h", dout, exp); end
    tests++; if (halt_req !== 1'b0) begin fails++; $display("FAIL ctrl_halt_clear got %b want 0", halt_req); end
    scan(2'd0, 4, 16'h000B, dout);
    tests++; if (dout !== 16'h0006) begin fails++; $display("FAIL bypass_echo got %h want 0006", dout); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] dout;
    logic        o;
    dbg_wr_ready = 1'b0;
    scan(2'd1, 16, 16'h5555, dout);
    push_rd(16'h7777);
    @(negedge clk);
    tests++; if (ir_out !== 2'b01 || dbg_wr_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pending got ir_out=%b valid=%b want 01/1", ir_out, dbg_wr_valid);
    end
    ir_in = 2'd1;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, o);
    cdr = 1'b0; sdr = 1'b1; tdi = 1'b1;
    #50 tck = 1'b1;
    #30 reset_n = 1'b0;
    #30 tck = 1'b0; sdr = 1'b0;
    #30 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    scan(2'd2, 16, 16'h0000, dout);
    tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL mid_fresh_read got %h want 0000", dout); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_write();
    test_back_to_back();
    test_overflow();
    dbg_wr_ready = 1'b0;
    do_reset();
    test_read();
    test_read_race();
    test_ctrl();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
